// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: in-order pipeline results take priority over a
// 4-entry FIFO of multicycle results, with a pending scoreboard for hazard queries.
module wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_valid,
  input  logic [4:0]  p_wa,
  input  logic [63:0] p_wd,
  input  logic        m_valid,
  input  logic [4:0]  m_wa,
  input  logic [63:0] m_wd,
  output logic        m_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wa,
  input  logic [4:0]  qa1,
  input  logic [4:0]  qa2,
  output logic        qbusy1,
  output logic        qbusy2,
  output logic        wen,
  output logic [4:0]  wa,
  output logic [63:0] wd,
  output logic [2:0]  fifo_cnt
);

  logic [4:0]  fifo_wa_q [4];
  logic [63:0] fifo_wd_q [4];
  logic [1:0]  head_q, tail_q;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pend_q, pend_d;
  logic        wen_q;
  logic [4:0]  wa_q;
  logic [63:0] wd_q;

  logic        push, sel_p, pop;
  logic [4:0]  head_wa;
  logic [63:0] head_wd;

  // Readiness comes from the registered count only, so a full FIFO never accepts
  // a push even when it is being popped in the same cycle.
  assign m_ready = (cnt_q < 3'd4) && !reset;
  assign push    = m_valid && m_ready;
  assign sel_p   = p_valid && (p_wa != 5'd0);
  assign pop     = !sel_p && (cnt_q != 3'd0);
  assign head_wa = fifo_wa_q[head_q];
  assign head_wd = fifo_wd_q[head_q];

  assign qbusy1 = (qa1 != 5'd0) && pend_q[qa1];
  assign qbusy2 = (qa2 != 5'd0) && pend_q[qa2];

  assign wen      = wen_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign fifo_cnt = cnt_q;

  always_comb begin
    pend_d = pend_q;
    if (pop && (head_wa != 5'd0)) pend_d[head_wa] = 1'b0;
    // A new issue to the same register outranks the retiring write.
    if (iss_valid && (iss_wa != 5'd0)) pend_d[iss_wa] = 1'b1;
    pend_d[0] = 1'b0;
    cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wa_q[tail_q] <= m_wa;
      fifo_wd_q[tail_q] <= m_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= 2'd0;
      tail_q <= 2'd0;
      cnt_q  <= 3'd0;
      pend_q <= 32'd0;
      wen_q  <= 1'b0;
      wa_q   <= 5'd0;
      wd_q   <= 64'd0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      if (push) tail_q <= tail_q + 2'd1;
      if (pop)  head_q <= head_q + 2'd1;
      if (sel_p) begin
        wen_q <= 1'b1;
        wa_q  <= p_wa;
        wd_q  <= p_wd;
      end else if (pop && (head_wa != 5'd0)) begin
        wen_q <= 1'b1;
        wa_q  <= head_wa;
        wd_q  <= head_wd;
      end else begin
        wen_q <= 1'b0;
      end
    end
  end

endmodule
